multi_nibble_sub_ctrl: RTL
==========================

MULTI_NIBBLE_SUB_CTRL -- requirements
Module: multi_nibble_sub_ctrl

Interface
REQ-001 The block SHALL have one clock and synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter NIBBLES, default 4: number of 4-bit slices per operand. Operand width W = 4*NIBBLES.
REQ-003 Port clk, input, 1: system clock.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port start, input, 1: request a subtraction; sampled only while ready=1.
REQ-006 Port a, input, W: minuend, captured when start is accepted.
REQ-007 Port b, input, W: subtrahend, captured when start is accepted.
REQ-008 Port bin, input, 1: borrow-in to slice 0, captured when start is accepted.
REQ-009 Port ready, output, 1: block idle and accepting start.
REQ-010 Port done, output, 1: one-cycle pulse; diff and bout are valid.
REQ-011 Port diff, output, W: result a - b - bin, modulo 2^W.
REQ-012 Port bout, output, 1: final borrow-out of the top slice.

Function
REQ-013 The FSM SHALL have two states: IDLE (ready=1) and RUN (ready=0).
REQ-014 IDLE with start=1 at an edge SHALL latch a, b and bin, clear the slice index to 0 and enter RUN; start=0 SHALL keep the FSM in IDLE.
REQ-015 Each RUN edge SHALL feed slice idx of the latched a and b, plus the borrow register, to one shared 4-bit subtractor.
REQ-016 Each RUN edge SHALL write the 4-bit difference into diff[4*idx+3:4*idx], load the slice borrow-out into the borrow register and increment idx.
REQ-017 The borrow register SHALL be loaded from bin on accept, giving borrow ripple across cycles least-significant slice first.
REQ-018 The RUN edge that processes idx=NIBBLES-1 SHALL load bout, assert done for exactly the following cycle and return the FSM to IDLE.
REQ-019 Latency SHALL be exactly NIBBLES cycles from the edge that accepts start to the cycle in which done=1.
REQ-020 In the done cycle ready SHALL be 1, so back-to-back start is accepted with no gap cycle.
REQ-021 start while in RUN SHALL be ignored, and changes on a, b and bin during RUN SHALL have no effect on the result.
REQ-022 diff and bout SHALL hold their last result until the next accepted start.
REQ-023 Slices of diff not yet written in the current operation SHALL read 0; diff SHALL clear on accept.
REQ-024 The idx counter SHALL be ceil(log2(NIBBLES))-bit (minimum 1 bit) and SHALL never exceed NIBBLES-1.

Reset
REQ-025 rst=1 SHALL force IDLE, ready=1, done=0, diff=0, bout=0, idx=0 and borrow=0 at the next edge.
REQ-026 rst SHALL take priority over start and over an operation in progress; a reset in mid-RUN SHALL abort the operation with no done pulse.
REQ-027 The first start SHALL be accepted on the first edge after rst deasserts.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE, RUN) and the slice width constant SLICE_W=4.
REQ-029 The per-slice arithmetic SHALL be one instance of the team's existing 4-bit borrow-lookahead subtractor, Lab2_4_bit_BLS_dataflow (ports A, B, bin, D, bout).
REQ-030 The block SHALL contain no other arithmetic and SHALL not use a W-bit subtract operator.

Verification
REQ-031 Bench SHALL apply a=0x0000, b=0x000C, bin=1 -> done 4 cycles after accept, diff=0xFFF3, bout=1.
REQ-032 Bench SHALL apply a=0x8000, b=0x0001, bin=0 -> borrow ripples through slices 0-2, diff=0x7FFF, bout=0.
REQ-033 Bench SHALL apply a=0xFFFF, b=0xFFFF, bin=1 -> diff=0xFFFF, bout=1; then start in the done cycle with a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, with no idle gap.
REQ-034 Bench SHALL pulse start and change a/b at RUN cycle 2 -> both are ignored, the original result holds and ready=0 throughout RUN.
REQ-035 Bench SHALL assert rst at RUN cycle 2 -> no done pulse, ready=1, diff=0 and bout=0 next cycle, and the next operation is correct.
REQ-036 Bench SHALL compare every result against a W-bit reference model over 1000 random operands.

Source files
------------

// File: rtl/multi_nibble_sub_ctrl_pkg.sv
// Shared types and constants for the nibble-serial subtractor controller.
package multi_nibble_sub_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Slice index width: ceil(log2(n)), never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/Lab2_4_bit_BLS_dataflow.sv
// 4-bit borrow-lookahead subtractor: D = A - B - bin, bout = borrow out of bit 3.
module Lab2_4_bit_BLS_dataflow (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       bin,
  output logic [3:0] D,
  output logic       bout
);

  logic [3:0] gen_s;
  logic [3:0] prop_s;
  logic [4:0] brw_s;

  // A bit generates a borrow when 0-1, and passes one through when its bits are equal.
  assign gen_s  = ~A & B;
  assign prop_s = ~(A ^ B);

  assign brw_s[0] = bin;
  assign brw_s[1] = gen_s[0] | (prop_s[0] & bin);
  assign brw_s[2] = gen_s[1] | (prop_s[1] & gen_s[0]) | (prop_s[1] & prop_s[0] & bin);
  assign brw_s[3] = gen_s[2] | (prop_s[2] & gen_s[1]) | (prop_s[2] & prop_s[1] & gen_s[0])
                  | (prop_s[2] & prop_s[1] & prop_s[0] & bin);
  assign brw_s[4] = gen_s[3] | (prop_s[3] & gen_s[2]) | (prop_s[3] & prop_s[2] & gen_s[1])
                  | (prop_s[3] & prop_s[2] & prop_s[1] & gen_s[0])
                  | (prop_s[3] & prop_s[2] & prop_s[1] & prop_s[0] & bin);

  assign D    = A ^ B ^ brw_s[3:0];
  assign bout = brw_s[4];

endmodule

// File: rtl/multi_nibble_sub_ctrl.sv
// Nibble-serial W-bit subtractor: one shared 4-bit slice processes a - b - bin
// least-significant nibble first, one nibble per clock.
module multi_nibble_sub_ctrl
  import multi_nibble_sub_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [SLICE_W*NIBBLES-1:0] a,
  input  logic [SLICE_W*NIBBLES-1:0] b,
  input  logic                       bin,
  output logic                       ready,
  output logic                       done,
  output logic [SLICE_W*NIBBLES-1:0] diff,
  output logic                       bout
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_t               state_r;
  state_t               state_next_s;
  logic [W-1:0]         a_r;
  logic [W-1:0]         b_r;
  logic [W-1:0]         diff_r;
  logic [W-1:0]         diff_next_s;
  logic [IW-1:0]        idx_r;
  logic                 borrow_r;
  logic                 bout_r;
  logic                 done_r;
  logic                 ready_r;
  logic [SLICE_W-1:0]   slice_a_s;
  logic [SLICE_W-1:0]   slice_b_s;
  logic [SLICE_W-1:0]   slice_d_s;
  logic                 slice_bout_s;
  logic                 accept_s;
  logic                 last_s;

  assign accept_s = (state_r == IDLE) && start;
  assign last_s   = (state_r == RUN) && (idx_r == LAST_IDX);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (idx_r == LAST_IDX) state_next_s = IDLE;
        else                   state_next_s = RUN;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Select the active nibble of the latched operands and merge its result into diff
  always_comb begin
    slice_a_s   = {SLICE_W{1'b0}};
    slice_b_s   = {SLICE_W{1'b0}};
    diff_next_s = diff_r;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_r == IW'(i)) begin
        slice_a_s = a_r[i*SLICE_W +: SLICE_W];
        slice_b_s = b_r[i*SLICE_W +: SLICE_W];
        diff_next_s[i*SLICE_W +: SLICE_W] = slice_d_s;
      end else begin
        diff_next_s[i*SLICE_W +: SLICE_W] = diff_r[i*SLICE_W +: SLICE_W];
      end
    end
  end

  Lab2_4_bit_BLS_dataflow u_slice_sub (
    .A    (slice_a_s),
    .B    (slice_b_s),
    .bin  (borrow_r),
    .D    (slice_d_s),
    .bout (slice_bout_s)
  );

  // Operand capture, borrow ripple across cycles, result and handshake registers
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      diff_r   <= {W{1'b0}};
      idx_r    <= {IW{1'b0}};
      borrow_r <= 1'b0;
      bout_r   <= 1'b0;
      done_r   <= 1'b0;
      ready_r  <= 1'b1;
    end else if (accept_s) begin
      a_r      <= a;
      b_r      <= b;
      borrow_r <= bin;
      diff_r   <= {W{1'b0}};
      bout_r   <= 1'b0;
      idx_r    <= {IW{1'b0}};
      done_r   <= 1'b0;
      ready_r  <= 1'b0;
    end else if (state_r == RUN) begin
      diff_r   <= diff_next_s;
      borrow_r <= slice_bout_s;
      if (last_s) begin
        idx_r   <= {IW{1'b0}};
        bout_r  <= slice_bout_s;
        done_r  <= 1'b1;
        ready_r <= 1'b1;
      end else begin
        idx_r   <= idx_r + IW'(1);
        done_r  <= 1'b0;
        ready_r <= 1'b0;
      end
    end else begin
      done_r  <= 1'b0;
      ready_r <= 1'b1;
    end
  end

  assign ready = ready_r;
  assign done  = done_r;
  assign diff  = diff_r;
  assign bout  = bout_r;

endmodule
